irrigation_zone_scheduler: RTL and testbench

//  Shares one pump and water tank among N_ZONES irrigation zones, granting one zone at a time.

---
 rtl/irrigation_zone_scheduler_if.sv | 28 ++
 rtl/irrigation_zone_scheduler.sv | 137 +++++++++++++
 tb/tb_irrigation_zone_scheduler.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/irrigation_zone_scheduler_if.sv
// Zone request / valve-pump control bundle for the irrigation scheduler.
// master drives requests and tank status; slave is the scheduler.
interface irrigation_zone_scheduler_if #(
    parameter int N_ZONES = 4
);
    localparam int ID_W = $clog2(N_ZONES);

    logic [N_ZONES-1:0] req;
    logic               water_ok;
    logic               tank_fault;
    logic               err_clr;
    logic [N_ZONES-1:0] valve;
    logic               pump_on;
    logic [ID_W-1:0]    grant_id;
    logic               busy;
    logic               done_pulse;
    logic               error;

    modport master (
        output req, water_ok, tank_fault, err_clr,
        input  valve, pump_on, grant_id, busy, done_pulse, error
    );

    modport slave (
        input  req, water_ok, tank_fault, err_clr,
        output valve, pump_on, grant_id, busy, done_pulse, error
    );
endinterface

// File: rtl/irrigation_zone_scheduler.sv
// Round-robin pump/tank sharing across irrigation zones with a timed
// open / water / stop valve sequence per grant.
module irrigation_zone_scheduler #(
    parameter int N_ZONES       = 4,
    parameter int TIMER_W       = 8,
    parameter int WATER_CYCLES  = 100,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    irrigation_zone_scheduler_if.slave bus
);
    localparam int ID_W = $clog2(N_ZONES);
    localparam logic [TIMER_W-1:0] SETTLE_LD = TIMER_W'(SETTLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] WATER_LD  = TIMER_W'(WATER_CYCLES - 1);
    localparam logic [ID_W-1:0]    LAST_ID   = ID_W'(N_ZONES - 1);

    typedef enum logic [2:0] {IDLE, OPEN, WATER, STOP, FAULT} state_t;

    state_t             state_q;
    logic [TIMER_W-1:0] timer_q;
    logic [ID_W-1:0]    rr_q;
    logic [ID_W-1:0]    grant_q;
    logic [N_ZONES-1:0] valve_q;
    logic               pump_q;
    logic               busy_q;
    logic               done_q;
    logic               error_q;

    logic [ID_W-1:0]    pick_d;
    logic               found_d;
    logic               abort_d;

    function automatic logic [N_ZONES-1:0] onehot(input logic [ID_W-1:0] id);
        onehot     = '0;
        onehot[id] = 1'b1;
    endfunction

    // Cyclic scan starting at rr_q; first set request wins.
    always_comb begin
        logic [ID_W-1:0] idx;
        pick_d  = rr_q;
        found_d = 1'b0;
        for (int i = 0; i < N_ZONES; i++) begin
            idx = ID_W'((int'(rr_q) + i) % N_ZONES);
            if (!found_d && bus.req[idx]) begin
                found_d = 1'b1;
                pick_d  = idx;
            end
        end
    end

    assign abort_d = !bus.req[grant_q] || !bus.water_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            rr_q    <= '0;
            grant_q <= '0;
            valve_q <= '0;
            pump_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.tank_fault) begin
                state_q <= FAULT;
                timer_q <= '0;
                valve_q <= '0;
                pump_q  <= 1'b0;
                busy_q  <= 1'b0;
                error_q <= 1'b1;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (bus.water_ok && found_d) begin
                            state_q <= OPEN;
                            grant_q <= pick_d;
                            timer_q <= SETTLE_LD;
                            valve_q <= onehot(pick_d);
                            busy_q  <= 1'b1;
                        end
                    end
                    OPEN: begin
                        if (abort_d) begin
                            state_q <= STOP;
                            timer_q <= SETTLE_LD;
                        end else if (timer_q == '0) begin
                            state_q <= WATER;
                            timer_q <= WATER_LD;
                            pump_q  <= 1'b1;
                        end else begin
                            timer_q <= timer_q - 1'b1;
                        end
                    end
                    WATER: begin
                        if (abort_d || timer_q == '0) begin
                            state_q <= STOP;
                            timer_q <= SETTLE_LD;
                            pump_q  <= 1'b0;
                        end else begin
                            timer_q <= timer_q - 1'b1;
                        end
                    end
                    STOP: begin
                        if (timer_q == '0) begin
                            state_q <= IDLE;
                            rr_q    <= (grant_q == LAST_ID) ? '0
                                                            : grant_q + ID_W'(1);
                            valve_q <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            timer_q <= timer_q - 1'b1;
                        end
                    end
                    FAULT: begin
                        if (bus.err_clr) begin
                            state_q <= IDLE;
                            error_q <= 1'b0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.valve      = valve_q;
    assign bus.pump_on    = pump_q;
    assign bus.grant_id   = grant_q;
    assign bus.busy       = busy_q;
    assign bus.done_pulse = done_q;
    assign bus.error      = error_q;
endmodule

// File: tb/tb_irrigation_zone_scheduler.sv
// Directed bench for irrigation_zone_scheduler (4 zones, water 10, settle 2).
module tb_irrigation_zone_scheduler;
    logic clk;
    logic reset;
    int   tests;
    int   fails;

    irrigation_zone_scheduler_if #(.N_ZONES(4)) bus ();

    irrigation_zone_scheduler #(
        .N_ZONES      (4),
        .TIMER_W      (8),
        .WATER_CYCLES (10),
        .SETTLE_CYCLES(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (!bus.busy) break;
            tick();
        end
        chk(tag, 32'(bus.busy), 32'd0);
    endtask

    int         vc, pc, fp, dc, dcyc, n, bad;
    logic [3:0] prev;
    logic [1:0] got [5];

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        bus.req = '0;
        bus.water_ok = 1'b0;
        bus.tank_fault = 1'b0;
        bus.err_clr = 1'b0;
        repeat (3) tick();
        chk("rst_valve", 32'(bus.valve), 32'd0);
        chk("rst_pump", 32'(bus.pump_on), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done_pulse), 32'd0);
        chk("rst_error", 32'(bus.error), 32'd0);
        chk("rst_grant", 32'(bus.grant_id), 32'd0);
        reset = 1'b0;

        // single zone, full sequence
        bus.req = 4'b0001;
        bus.water_ok = 1'b1;
        vc = 0; pc = 0; fp = 0; dc = 0; dcyc = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 1) chk("t1_latency", 32'(bus.valve), 32'h1);
            if (bus.valve == 4'b0001) vc++;
            if (bus.pump_on) begin
                pc++;
                if (fp == 0) fp = c;
            end
            if (bus.done_pulse) begin
                dc++;
                dcyc = c;
            end
            if (c == 13) bus.req = '0;
        end
        chk("t1_valve_cycles", 32'(vc), 32'd14);
        chk("t1_pump_cycles", 32'(pc), 32'd10);
        chk("t1_pump_start", 32'(fp), 32'd3);
        chk("t1_done_count", 32'(dc), 32'd1);
        chk("t1_done_cycle", 32'(dcyc), 32'd15);

        // round robin over all zones
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.req = 4'b1111;
        n = 0; bad = 0; prev = '0;
        for (int c = 0; c < 100 && n < 5; c++) begin
            tick();
            if ((bus.valve & (bus.valve - 4'd1)) != 4'd0) bad++;
            if (prev == 4'd0 && bus.valve != 4'd0) begin
                got[n] = bus.grant_id;
                if (bus.valve != (4'd1 << bus.grant_id)) bad++;
                n++;
            end
            prev = bus.valve;
        end
        chk("t2_grants", 32'(n), 32'd5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("t2_grant%0d", i), 32'(got[i]), 32'(i % 4));
        chk("t2_onehot", 32'(bad), 32'd0);
        bus.req = '0;
        wait_idle("t2_idle");

        // water_ok drops mid-WATER
        bus.req = 4'b0100;
        tick();
        chk("t3_grant", 32'(bus.grant_id), 32'd2);
        chk("t3_valve", 32'(bus.valve), 32'h4);
        tick();
        tick();
        chk("t3_pump_on", 32'(bus.pump_on), 32'd1);
        repeat (3) tick();
        bus.water_ok = 1'b0;
        tick();
        chk("t3_pump_off", 32'(bus.pump_on), 32'd0);
        chk("t3_valve_stop", 32'(bus.valve), 32'h4);
        tick();
        chk("t3_valve_stop2", 32'(bus.valve), 32'h4);
        tick();
        chk("t3_valve_off", 32'(bus.valve), 32'd0);
        chk("t3_done", 32'(bus.done_pulse), 32'd1);
        bus.water_ok = 1'b1;
        bus.req = '0;

        // tank fault during WATER
        bus.req = 4'b0001;
        repeat (3) tick();
        chk("t4_pump_on", 32'(bus.pump_on), 32'd1);
        repeat (2) tick();
        bus.tank_fault = 1'b1;
        tick();
        chk("t4_valve", 32'(bus.valve), 32'd0);
        chk("t4_pump", 32'(bus.pump_on), 32'd0);
        chk("t4_error", 32'(bus.error), 32'd1);
        chk("t4_busy", 32'(bus.busy), 32'd0);
        bus.err_clr = 1'b1;
        tick();
        chk("t4_clr_blocked", 32'(bus.error), 32'd1);
        bus.tank_fault = 1'b0;
        bus.req = '0;
        tick();
        chk("t4_cleared", 32'(bus.error), 32'd0);
        chk("t4_no_done", 32'(bus.done_pulse), 32'd0);
        bus.err_clr = 1'b0;
        bus.req = 4'b1001;
        tick();
        chk("t4_rr_kept", 32'(bus.grant_id), 32'd3);
        chk("t4_rr_valve", 32'(bus.valve), 32'h8);
        bus.req = '0;
        wait_idle("t4_idle");

        // no grant without water
        bus.req = 4'b0010;
        bus.water_ok = 1'b0;
        repeat (3) tick();
        chk("t5_dry_valve", 32'(bus.valve), 32'd0);
        chk("t5_dry_busy", 32'(bus.busy), 32'd0);
        bus.water_ok = 1'b1;
        tick();
        chk("t5_valve", 32'(bus.valve), 32'h2);
        chk("t5_grant", 32'(bus.grant_id), 32'd1);
        bus.req = '0;
        wait_idle("t5_idle");

        // asynchronous reset mid-OPEN
        bus.req = 4'b0001;
        tick();
        chk("t6_open", 32'(bus.busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_valve", 32'(bus.valve), 32'd0);
        chk("t6_rst_busy", 32'(bus.busy), 32'd0);
        chk("t6_rst_pump", 32'(bus.pump_on), 32'd0);
        tick();
        reset = 1'b0;
        bus.req = 4'b1001;
        tick();
        chk("t6_grant", 32'(bus.grant_id), 32'd0);
        chk("t6_valve", 32'(bus.valve), 32'h1);
        bus.req = '0;
        wait_idle("t6_idle");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
